// File: rtl/costas_acq_pkg.sv
// -----------------------------------------------------------------------------
// costas_acq_pkg
// Shared definitions for the Costas-loop acquisition controller:
//   - acq_state_t : controller state encoding (also exported on o_state)
//   - SMP_W       : width of the signed low-pass mixer samples
//   - ACC_BASE_W  : accumulator width before adding WIN_LOG2 growth bits
//   - GAIN_ACQ / GAIN_TRK : phase-detector step for acquisition / tracking
//   - abs_sat()   : magnitude of a signed sample, saturating the most
//                   negative code so the result always fits in SMP_W bits
// -----------------------------------------------------------------------------
package costas_acq_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LRST    = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_MEASURE = 3'd3,
      ST_NEXT    = 3'd4,
      ST_LOCKED  = 3'd5
   } acq_state_t;

   localparam int SMP_W      = 14;
   localparam int ACC_BASE_W = 16;

   localparam logic signed [31:0] GAIN_ACQ = 32'sd5000000;
   localparam logic signed [31:0] GAIN_TRK = 32'sd1250000;

   localparam logic signed [SMP_W-1:0] SMP_MAX = 14'sd8191;
   localparam logic signed [SMP_W-1:0] SMP_MIN = {1'b1, {(SMP_W-1){1'b0}}};

   // |x| with -2^(SMP_W-1) mapped to 2^(SMP_W-1)-1 instead of wrapping negative.
   function automatic logic signed [SMP_W-1:0] abs_sat(input logic signed [SMP_W-1:0] x);
      logic signed [SMP_W-1:0] r;
      if (x == SMP_MIN) begin
         r = SMP_MAX;
      end else if (x[SMP_W-1]) begin
         r = -x;
      end else begin
         r = x;
      end
      return r;
   endfunction

endpackage

// File: rtl/costas_lock_meter.sv
// -----------------------------------------------------------------------------
// costas_lock_meter
// Accumulates m = |I| - |Q| over windows of 2^WIN_LOG2 valid samples and
// reports, in the cycle the last sample of a window is taken, whether the
// window mean (acc >>> WIN_LOG2) reaches LOCK_THR. Windows run back-to-back
// while i_run is high; dropping i_run clears the accumulator and count.
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous active-high reset
//   i_en         global enable; when low the accumulator and count hold
//   i_run        measurement active (MEASURE or LOCKED); low clears
//   i_smp_valid  sample on i_i/i_q is valid this cycle
//   i_i, i_q     signed SMP_W-bit low-pass mixer outputs
//   o_win_done   high in the cycle the final sample of a window is taken
//   o_pass       window mean >= LOCK_THR (meaningful with o_win_done)
// -----------------------------------------------------------------------------
module costas_lock_meter
   import costas_acq_pkg::*;
#(
   parameter int                      WIN_LOG2 = 10,
   parameter logic signed [SMP_W-1:0] LOCK_THR = 14'sd1024
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_en,
   input  logic                    i_run,
   input  logic                    i_smp_valid,
   input  logic signed [SMP_W-1:0] i_i,
   input  logic signed [SMP_W-1:0] i_q,
   output logic                    o_win_done,
   output logic                    o_pass
);

   localparam int ACC_W = ACC_BASE_W + WIN_LOG2;

   logic signed [ACC_W-1:0]  r_acc;
   logic [WIN_LOG2-1:0]      r_cnt;

   logic signed [SMP_W:0]    w_metric;
   logic signed [ACC_W-1:0]  w_metric_ext;
   logic signed [ACC_W-1:0]  w_acc_sum;
   logic signed [ACC_W-1:0]  w_mean;
   logic signed [ACC_W-1:0]  w_thr;
   logic                     w_take;
   logic                     w_last;

   // Both magnitudes are non-negative SMP_W-bit values, so one extra bit
   // holds their difference without overflow.
   assign w_metric     = $signed({1'b0, abs_sat(i_i)}) - $signed({1'b0, abs_sat(i_q)});
   assign w_metric_ext = {{(ACC_W-SMP_W-1){w_metric[SMP_W]}}, w_metric};
   assign w_acc_sum    = r_acc + w_metric_ext;
   assign w_mean       = w_acc_sum >>> WIN_LOG2;
   assign w_thr        = {{(ACC_W-SMP_W){LOCK_THR[SMP_W-1]}}, LOCK_THR};

   assign w_take     = i_en & i_run & i_smp_valid;
   assign w_last     = &r_cnt;
   // The decision includes the sample being taken this cycle, so the
   // controller can act in the same cycle the window closes.
   assign o_win_done = w_take & w_last;
   assign o_pass     = (w_mean >= w_thr);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc <= '0;
         r_cnt <= '0;
      end else if (i_en) begin
         if (!i_run) begin
            r_acc <= '0;
            r_cnt <= '0;
         end else if (i_smp_valid) begin
            if (w_last) begin
               r_acc <= '0;
               r_cnt <= '0;
            end else begin
               r_acc <= w_acc_sum;
               r_cnt <= r_cnt + WIN_LOG2'(1);
            end
         end
      end
   end

endmodule

// File: rtl/costas_acq_ctrl.sv
// -----------------------------------------------------------------------------
// costas_acq_ctrl
// Acquisition controller for a Costas carrier-recovery loop. Sweeps the NCO
// base increment over F_STEPS points; at each point it pulses the loop reset,
// lets the loop settle for SETTLE_CYC cycles, then measures one window of
// |I|-|Q|. A passing window declares lock; in LOCKED, windows are measured
// back-to-back and LOSS_WIN consecutive failures resume the sweep from the
// next point.
//
// Optional feature: define COSTAS_ACQ_GEARSHIFT_EN to drop the loop gain to
// the tracking value while locked. Without it the gain stays at the
// acquisition value.
//
// Ports:
//   i_clk          clock (100 MHz)
//   i_rst          synchronous active-high reset (priority over i_en)
//   i_en           global enable; when low all state and outputs hold
//   i_start        pulse: begin acquisition (ignored outside IDLE)
//   i_stop         pulse: abort to IDLE (wins over i_start)
//   i_smp_valid    i_i_lpf / i_q_lpf valid this cycle
//   i_i_lpf        signed 14-bit in-phase LPF output
//   i_q_lpf        signed 14-bit quadrature LPF output
//   o_nco_base     base phase increment for the loop DDS
//   o_loop_rst     loop datapath reset
//   o_loop_en      loop datapath enable
//   o_loop_gain    phase-detector step magnitude
//   o_locked       loop declared locked
//   o_sweep_idx    current sweep point index
//   o_sweep_wrap   one-cycle pulse when the index wraps to 0
//   o_state        current controller state (debug visibility)
// -----------------------------------------------------------------------------
module costas_acq_ctrl
   import costas_acq_pkg::*;
#(
   parameter logic [31:0]             F_START    = 32'd900000000,
   parameter logic [31:0]             F_STEP     = 32'd4294967,
   parameter int                      F_STEPS    = 16,
   parameter int                      SETTLE_CYC = 4096,
   parameter int                      WIN_LOG2   = 10,
   parameter logic signed [SMP_W-1:0] LOCK_THR   = 14'sd1024,
   parameter int                      LOSS_WIN   = 4
) (
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_en,
   input  logic                    i_start,
   input  logic                    i_stop,
   input  logic                    i_smp_valid,
   input  logic signed [SMP_W-1:0] i_i_lpf,
   input  logic signed [SMP_W-1:0] i_q_lpf,
   output logic [31:0]             o_nco_base,
   output logic                    o_loop_rst,
   output logic                    o_loop_en,
   output logic signed [31:0]      o_loop_gain,
   output logic                    o_locked,
   output logic [7:0]              o_sweep_idx,
   output logic                    o_sweep_wrap,
   output logic [2:0]              o_state
);

   localparam logic [7:0]  LAST_IDX    = 8'(F_STEPS - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYC - 1);
   localparam logic [3:0]  LOSS_LAST   = 4'(LOSS_WIN - 1);

   acq_state_t   r_state;
   logic [31:0]  r_nco_base;
   logic [7:0]   r_sweep_idx;
   logic         r_loop_rst;
   logic         r_loop_en;
   logic         r_locked;
   logic         r_sweep_wrap;
   logic [15:0]  r_settle_cnt;
   logic [3:0]   r_fail_cnt;

   logic         w_meas_run;
   logic         w_win_done;
   logic         w_win_pass;

   assign w_meas_run = (r_state == ST_MEASURE) || (r_state == ST_LOCKED);

   costas_lock_meter #(
      .WIN_LOG2 (WIN_LOG2),
      .LOCK_THR (LOCK_THR)
   ) u_meter (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_en        (i_en),
      .i_run       (w_meas_run),
      .i_smp_valid (i_smp_valid),
      .i_i         (i_i_lpf),
      .i_q         (i_q_lpf),
      .o_win_done  (w_win_done),
      .o_pass      (w_win_pass)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state      <= ST_IDLE;
         r_nco_base   <= F_START;
         r_sweep_idx  <= '0;
         r_loop_rst   <= 1'b1;
         r_loop_en    <= 1'b0;
         r_locked     <= 1'b0;
         r_sweep_wrap <= 1'b0;
         r_settle_cnt <= '0;
         r_fail_cnt   <= '0;
      end else if (i_en) begin
         r_sweep_wrap <= 1'b0;
         if (i_stop) begin
            r_state      <= ST_IDLE;
            r_nco_base   <= F_START;
            r_sweep_idx  <= '0;
            r_loop_rst   <= 1'b0;
            r_loop_en    <= 1'b0;
            r_locked     <= 1'b0;
            r_settle_cnt <= '0;
            r_fail_cnt   <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  r_nco_base  <= F_START;
                  r_sweep_idx <= '0;
                  r_loop_en   <= 1'b0;
                  r_loop_rst  <= 1'b0;
                  if (i_start) begin
                     r_loop_rst <= 1'b1;
                     r_state    <= ST_LRST;
                  end
               end

               ST_LRST: begin
                  r_loop_rst   <= 1'b0;
                  r_loop_en    <= 1'b1;
                  r_settle_cnt <= '0;
                  r_state      <= ST_SETTLE;
               end

               ST_SETTLE: begin
                  if (r_settle_cnt == SETTLE_LAST) begin
                     r_settle_cnt <= '0;
                     r_state      <= ST_MEASURE;
                  end else begin
                     r_settle_cnt <= r_settle_cnt + 16'd1;
                  end
               end

               ST_MEASURE: begin
                  if (w_win_done) begin
                     if (w_win_pass) begin
                        r_locked   <= 1'b1;
                        r_fail_cnt <= '0;
                        r_state    <= ST_LOCKED;
                     end else begin
                        r_loop_en <= 1'b0;
                        r_state   <= ST_NEXT;
                     end
                  end
               end

               ST_NEXT: begin
                  if (r_sweep_idx == LAST_IDX) begin
                     r_sweep_idx  <= '0;
                     r_nco_base   <= F_START;
                     r_sweep_wrap <= 1'b1;
                  end else begin
                     r_sweep_idx <= r_sweep_idx + 8'd1;
                     r_nco_base  <= r_nco_base + F_STEP;
                  end
                  r_loop_rst <= 1'b1;
                  r_state    <= ST_LRST;
               end

               ST_LOCKED: begin
                  if (w_win_done) begin
                     if (w_win_pass) begin
                        r_fail_cnt <= '0;
                     end else if (r_fail_cnt == LOSS_LAST) begin
                        // Loss of lock: resume the sweep at the following point.
                        r_fail_cnt <= '0;
                        r_locked   <= 1'b0;
                        r_loop_en  <= 1'b0;
                        r_state    <= ST_NEXT;
                     end else begin
                        r_fail_cnt <= r_fail_cnt + 4'd1;
                     end
                  end
               end

               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

   assign o_nco_base   = r_nco_base;
   assign o_sweep_idx  = r_sweep_idx;
   assign o_loop_rst   = r_loop_rst;
   assign o_loop_en    = r_loop_en;
   assign o_locked     = r_locked;
   assign o_sweep_wrap = r_sweep_wrap;
   assign o_state      = r_state;

   // Gain follows the registered lock flag, so it switches in the same cycle
   // o_locked changes.
`ifdef COSTAS_ACQ_GEARSHIFT_EN
   assign o_loop_gain = r_locked ? GAIN_TRK : GAIN_ACQ;
`else
   assign o_loop_gain = GAIN_ACQ;
`endif

endmodule
